// File: rtl/decoder_stage_riscv_pkg.sv
// decoder_stage_riscv_pkg: RV32I decode encodings shared by the decode stage, its decoder and its interface.
package decoder_stage_riscv_pkg;
  localparam int ALU_OP_WIDTH = 5;
  localparam logic [ALU_OP_WIDTH-1:0] ALU_ADD  = 5'b00000;
  localparam logic [ALU_OP_WIDTH-1:0] ALU_SUB  = 5'b01000;
  localparam logic [ALU_OP_WIDTH-1:0] ALU_XOR  = 5'b00100;
  localparam logic [ALU_OP_WIDTH-1:0] ALU_OR   = 5'b00110;
  localparam logic [ALU_OP_WIDTH-1:0] ALU_AND  = 5'b00111;
  localparam logic [ALU_OP_WIDTH-1:0] ALU_SRA  = 5'b01101;
  localparam logic [ALU_OP_WIDTH-1:0] ALU_SRL  = 5'b00101;
  localparam logic [ALU_OP_WIDTH-1:0] ALU_SLL  = 5'b00001;
  localparam logic [ALU_OP_WIDTH-1:0] ALU_LTS  = 5'b11100;
  localparam logic [ALU_OP_WIDTH-1:0] ALU_LTU  = 5'b11110;
  localparam logic [ALU_OP_WIDTH-1:0] ALU_GES  = 5'b11101;
  localparam logic [ALU_OP_WIDTH-1:0] ALU_GEU  = 5'b11111;
  localparam logic [ALU_OP_WIDTH-1:0] ALU_EQ   = 5'b11000;
  localparam logic [ALU_OP_WIDTH-1:0] ALU_NE   = 5'b11001;
  localparam logic [ALU_OP_WIDTH-1:0] ALU_SLTS = 5'b00010;
  localparam logic [ALU_OP_WIDTH-1:0] ALU_SLTU = 5'b00011;
  localparam logic [1:0] OP_A_RS1     = 2'd0;
  localparam logic [1:0] OP_A_CURR_PC = 2'd1;
  localparam logic [1:0] OP_A_ZERO    = 2'd2;
  localparam logic [2:0] OP_B_RS2   = 3'd0;
  localparam logic [2:0] OP_B_IMM_I = 3'd1;
  localparam logic [2:0] OP_B_IMM_U = 3'd2;
  localparam logic [2:0] OP_B_IMM_S = 3'd3;
  localparam logic [2:0] OP_B_INCR  = 3'd4;
  localparam logic [2:0] LDST_B  = 3'd0;
  localparam logic [2:0] LDST_H  = 3'd1;
  localparam logic [2:0] LDST_W  = 3'd2;
  localparam logic [2:0] LDST_BU = 3'd4;
  localparam logic [2:0] LDST_HU = 3'd5;
  localparam logic WB_EX_RESULT = 1'b0;
  localparam logic WB_LSU_DATA  = 1'b1;
  localparam logic [4:0] LOAD_OPCODE     = 5'b00000;
  localparam logic [4:0] MISC_MEM_OPCODE = 5'b00011;
  localparam logic [4:0] OP_IMM_OPCODE   = 5'b00100;
  localparam logic [4:0] AUIPC_OPCODE    = 5'b00101;
  localparam logic [4:0] STORE_OPCODE    = 5'b01000;
  localparam logic [4:0] OP_OPCODE       = 5'b01100;
  localparam logic [4:0] LUI_OPCODE      = 5'b01101;
  localparam logic [4:0] BRANCH_OPCODE   = 5'b11000;
  localparam logic [4:0] JALR_OPCODE     = 5'b11001;
  localparam logic [4:0] JAL_OPCODE      = 5'b11011;
  localparam logic [4:0] SYSTEM_OPCODE   = 5'b11100;
  localparam logic [31:0] DS_NOP_INSTR = 32'h0000_0013;
endpackage

// File: rtl/decoder_stage_riscv_if.sv
// decoder_stage_riscv_if: fetch, execute, flush and trap signals of the decode stage.
interface decoder_stage_riscv_if #(parameter int DEPTH = 2, parameter int PC_WIDTH = 32);
  import decoder_stage_riscv_pkg::*;
  logic fetch_valid_i;
  logic fetch_ready_o;
  logic [31:0] fetched_instr_i;
  logic [PC_WIDTH-1:0] fetched_pc_i;
  logic flush_i;
  logic ex_valid_o;
  logic ex_ready_i;
  logic [31:0] ex_instr_o;
  logic [PC_WIDTH-1:0] ex_pc_o;
  logic [1:0] ex_op_a_sel_o;
  logic [2:0] ex_op_b_sel_o;
  logic [ALU_OP_WIDTH-1:0] alu_op_o;
  logic mem_req_o;
  logic mem_we_o;
  logic [2:0] mem_size_o;
  logic gpr_we_a_o;
  logic wb_src_sel_o;
  logic branch_o;
  logic jal_o;
  logic jalr_o;
  logic trap_o;
  logic [31:0] trap_instr_o;
  logic [PC_WIDTH-1:0] trap_pc_o;
  logic trap_ack_i;
  logic [$clog2(DEPTH+1)-1:0] queue_count_o;
  modport master (
    output fetch_valid_i, fetched_instr_i, fetched_pc_i, flush_i, ex_ready_i, trap_ack_i,
    input fetch_ready_o, ex_valid_o, ex_instr_o, ex_pc_o, ex_op_a_sel_o, ex_op_b_sel_o, alu_op_o,
          mem_req_o, mem_we_o, mem_size_o, gpr_we_a_o, wb_src_sel_o, branch_o, jal_o, jalr_o,
          trap_o, trap_instr_o, trap_pc_o, queue_count_o
  );
  modport slave (
    input fetch_valid_i, fetched_instr_i, fetched_pc_i, flush_i, ex_ready_i, trap_ack_i,
    output fetch_ready_o, ex_valid_o, ex_instr_o, ex_pc_o, ex_op_a_sel_o, ex_op_b_sel_o, alu_op_o,
           mem_req_o, mem_we_o, mem_size_o, gpr_we_a_o, wb_src_sel_o, branch_o, jal_o, jalr_o,
           trap_o, trap_instr_o, trap_pc_o, queue_count_o
  );
endinterface

// File: rtl/decoder_stage_riscv_decoder.sv
// decoder_riscv: RV32I main decoder producing execute control signals and an illegal flag.
module decoder_riscv import decoder_stage_riscv_pkg::*; (
  input  logic [31:0]             fetched_instr_i,
  output logic [1:0]              ex_op_a_sel_o,
  output logic [2:0]              ex_op_b_sel_o,
  output logic [ALU_OP_WIDTH-1:0] alu_op_o,
  output logic                    mem_req_o,
  output logic                    mem_we_o,
  output logic [2:0]              mem_size_o,
  output logic                    gpr_we_a_o,
  output logic                    wb_src_sel_o,
  output logic                    illegal_instr_o,
  output logic                    branch_o,
  output logic                    jal_o,
  output logic                    jalr_o
);
  logic [4:0] w_opc;
  logic [2:0] w_f3;
  logic [6:0] w_f7;
  logic w_bad;
  assign w_opc = fetched_instr_i[6:2];
  assign w_f3  = fetched_instr_i[14:12];
  assign w_f7  = fetched_instr_i[31:25];
  always_comb begin
    ex_op_a_sel_o = OP_A_RS1;
    ex_op_b_sel_o = OP_B_RS2;
    alu_op_o = ALU_ADD;
    mem_req_o = 1'b0;
    mem_we_o = 1'b0;
    mem_size_o = LDST_W;
    gpr_we_a_o = 1'b0;
    wb_src_sel_o = WB_EX_RESULT;
    branch_o = 1'b0;
    jal_o = 1'b0;
    jalr_o = 1'b0;
    w_bad = 1'b0;
    case (w_opc)
      LOAD_OPCODE: begin
        ex_op_b_sel_o = OP_B_IMM_I;
        mem_req_o = 1'b1;
        mem_size_o = w_f3;
        gpr_we_a_o = 1'b1;
        wb_src_sel_o = WB_LSU_DATA;
        w_bad = (w_f3 == 3'd3) || (w_f3[2:1] == 2'b11);
      end
      STORE_OPCODE: begin
        ex_op_b_sel_o = OP_B_IMM_S;
        mem_req_o = 1'b1;
        mem_we_o = 1'b1;
        mem_size_o = w_f3;
        w_bad = w_f3 > 3'd2;
      end
      // ALU encodings are {0, funct7[5], funct3}; only SUB/SRA/SRAI may set funct7[5]
      OP_IMM_OPCODE: begin
        ex_op_b_sel_o = OP_B_IMM_I;
        gpr_we_a_o = 1'b1;
        alu_op_o = {1'b0, w_f7[5] & (w_f3 == 3'd5), w_f3};
        w_bad = ((w_f3 == 3'd1) && (w_f7 != 7'd0)) || ((w_f3 == 3'd5) && ({w_f7[6], w_f7[4:0]} != 6'd0));
      end
      OP_OPCODE: begin
        gpr_we_a_o = 1'b1;
        alu_op_o = {1'b0, w_f7[5], w_f3};
        w_bad = ({w_f7[6], w_f7[4:0]} != 6'd0) || (w_f7[5] && (w_f3 != 3'd0) && (w_f3 != 3'd5));
      end
      LUI_OPCODE: begin
        ex_op_a_sel_o = OP_A_ZERO;
        ex_op_b_sel_o = OP_B_IMM_U;
        gpr_we_a_o = 1'b1;
      end
      AUIPC_OPCODE: begin
        ex_op_a_sel_o = OP_A_CURR_PC;
        ex_op_b_sel_o = OP_B_IMM_U;
        gpr_we_a_o = 1'b1;
      end
      BRANCH_OPCODE: begin
        alu_op_o = {2'b11, w_f3};
        branch_o = 1'b1;
        w_bad = w_f3[2:1] == 2'b01;
      end
      JAL_OPCODE: begin
        ex_op_a_sel_o = OP_A_CURR_PC;
        ex_op_b_sel_o = OP_B_INCR;
        gpr_we_a_o = 1'b1;
        jal_o = 1'b1;
      end
      JALR_OPCODE: begin
        ex_op_a_sel_o = OP_A_CURR_PC;
        ex_op_b_sel_o = OP_B_INCR;
        gpr_we_a_o = 1'b1;
        jalr_o = 1'b1;
        w_bad = w_f3 != 3'd0;
      end
      MISC_MEM_OPCODE: w_bad = w_f3 != 3'd0;
      SYSTEM_OPCODE: w_bad = (fetched_instr_i != 32'h0000_0073) && (fetched_instr_i != 32'h0010_0073);
      default: w_bad = 1'b1;
    endcase
    illegal_instr_o = (fetched_instr_i[1:0] != 2'b11) || w_bad;
  end
endmodule

// File: rtl/decoder_stage_riscv.sv
// decoder_stage_riscv: queued decode stage between fetch and execute; illegal heads
// raise a held trap instead of reaching execute.
module decoder_stage_riscv import decoder_stage_riscv_pkg::*; #(
  parameter int DEPTH = 2,
  parameter int PC_WIDTH = 32
) (
  input logic clk_i,
  input logic rst_i,
  decoder_stage_riscv_if.slave bus
);
  localparam int AW = $clog2(DEPTH);
  localparam int CW = $clog2(DEPTH + 1);
  typedef enum logic {S_RUN, S_TRAP} state_t;
  state_t r_state, w_state_next;
  logic [31:0] r_instr_q [DEPTH];
  logic [PC_WIDTH-1:0] r_pc_q [DEPTH];
  logic [AW-1:0] r_rptr, r_wptr;
  logic [CW-1:0] r_count;
  logic [31:0] r_trap_instr;
  logic [PC_WIDTH-1:0] r_trap_pc;
  logic [31:0] w_head_instr;
  logic [PC_WIDTH-1:0] w_head_pc;
  logic [1:0] w_op_a;
  logic [2:0] w_op_b, w_size;
  logic [ALU_OP_WIDTH-1:0] w_alu;
  logic w_req, w_we, w_gpr_we, w_wb, w_illegal, w_br, w_jal, w_jalr;
  logic w_fetch_ready, w_ex_valid, w_push, w_pop, w_trap_hit;
  assign w_head_instr = r_instr_q[r_rptr];
  assign w_head_pc = r_pc_q[r_rptr];
  decoder_riscv u_dec (
    .fetched_instr_i (w_head_instr),
    .ex_op_a_sel_o   (w_op_a),
    .ex_op_b_sel_o   (w_op_b),
    .alu_op_o        (w_alu),
    .mem_req_o       (w_req),
    .mem_we_o        (w_we),
    .mem_size_o      (w_size),
    .gpr_we_a_o      (w_gpr_we),
    .wb_src_sel_o    (w_wb),
    .illegal_instr_o (w_illegal),
    .branch_o        (w_br),
    .jal_o           (w_jal),
    .jalr_o          (w_jalr)
  );
  assign w_fetch_ready = (r_state == S_RUN) && (r_count < CW'(DEPTH));
  assign w_ex_valid = (r_count != '0) && !w_illegal && (r_state == S_RUN);
  assign w_push = bus.fetch_valid_i && w_fetch_ready;
  assign w_pop = w_ex_valid && bus.ex_ready_i;
  // A flush in the same cycle wins: the illegal head is simply discarded
  assign w_trap_hit = (r_state == S_RUN) && (r_count != '0) && w_illegal && !bus.flush_i;
  always_ff @(posedge clk_i or posedge rst_i)
    if (rst_i) r_state <= S_RUN;
    else r_state <= w_state_next;
  always_comb begin
    w_state_next = r_state;
    if (w_trap_hit) w_state_next = S_TRAP;
    if ((r_state == S_TRAP) && bus.trap_ack_i) w_state_next = S_RUN;
  end
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      r_count <= '0;
      r_rptr <= '0;
      r_wptr <= '0;
      r_trap_instr <= '0;
      r_trap_pc <= '0;
    end else begin
      if (w_trap_hit) begin
        r_trap_instr <= w_head_instr;
        r_trap_pc <= w_head_pc;
      end
      if (bus.flush_i || w_trap_hit) begin
        r_count <= '0;
        r_rptr <= '0;
        r_wptr <= '0;
      end else begin
        if (w_push) r_wptr <= r_wptr + AW'(1);
        if (w_pop) r_rptr <= r_rptr + AW'(1);
        r_count <= r_count + CW'(w_push) - CW'(w_pop);
      end
    end
  end
  always_ff @(posedge clk_i)
    if (w_push) begin
      r_instr_q[r_wptr] <= bus.fetched_instr_i;
      r_pc_q[r_wptr] <= bus.fetched_pc_i;
    end
  assign bus.fetch_ready_o = w_fetch_ready;
  assign bus.ex_valid_o = w_ex_valid;
  assign bus.ex_instr_o = w_ex_valid ? w_head_instr : DS_NOP_INSTR;
  assign bus.ex_pc_o = w_ex_valid ? w_head_pc : '0;
  assign bus.ex_op_a_sel_o = w_ex_valid ? w_op_a : OP_A_RS1;
  assign bus.ex_op_b_sel_o = w_ex_valid ? w_op_b : OP_B_RS2;
  assign bus.alu_op_o = w_ex_valid ? w_alu : ALU_ADD;
  assign bus.mem_req_o = w_ex_valid && w_req;
  assign bus.mem_we_o = w_ex_valid && w_we;
  assign bus.mem_size_o = w_ex_valid ? w_size : LDST_W;
  assign bus.gpr_we_a_o = w_ex_valid && w_gpr_we;
  assign bus.wb_src_sel_o = w_ex_valid ? w_wb : WB_EX_RESULT;
  assign bus.branch_o = w_ex_valid && w_br;
  assign bus.jal_o = w_ex_valid && w_jal;
  assign bus.jalr_o = w_ex_valid && w_jalr;
  assign bus.trap_o = r_state == S_TRAP;
  assign bus.trap_instr_o = r_trap_instr;
  assign bus.trap_pc_o = r_trap_pc;
  assign bus.queue_count_o = r_count;
endmodule
